// File: rtl/ffjk_seq_ctrl.sv
// Sequencer for an external bank of JK flip-flops. It accepts clear, load and
// up/down count commands and drives J/K so that the bank steps once per cycle.
module ffjk_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_CLR  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_UP   = 2'b10;
   localparam logic [1:0] OP_DOWN = 2'b11;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_op, w_op_nxt;
   logic [WIDTH-1:0] r_data, w_data_nxt;
   logic [WIDTH-1:0] r_rem, w_rem_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic [WIDTH-1:0] w_j, w_k;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down).
   function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] qv,
                                                    input logic up);
      logic [WIDTH-1:0] t;
      logic             run;
      t   = '0;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t[i] = run;
         run  = run & (up ? qv[i] : ~qv[i]);
      end
      return t;
   endfunction

   function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] qv,
                                                input logic [WIDTH-1:0] jv,
                                                input logic [WIDTH-1:0] kv);
      return (jv & ~qv) | (~kv & qv);
   endfunction

   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_data_nxt   = r_data;
      w_rem_nxt    = r_rem;
      w_result_nxt = r_result;
      w_j          = '0;
      w_k          = '0;

      if (r_state == ST_EXEC) begin
         case (r_op)
            OP_CLR:  begin w_j = '0;      w_k = '1;      end
            OP_LOAD: begin w_j = r_data;  w_k = ~r_data; end
            OP_UP:   begin w_j = toggle_mask(q, 1'b1); w_k = w_j; end
            OP_DOWN: begin w_j = toggle_mask(q, 1'b0); w_k = w_j; end
            default: begin w_j = '0;      w_k = '0;      end
         endcase
      end

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_op_nxt   = cmd_op;
               w_data_nxt = cmd_data;
               if (!cmd_op[1]) begin
                  w_rem_nxt   = WIDTH'(1);
                  w_state_nxt = ST_EXEC;
               end else if (cmd_data != '0) begin
                  w_rem_nxt   = cmd_data;
                  w_state_nxt = ST_EXEC;
               end else begin
                  w_rem_nxt    = '0;
                  w_result_nxt = q;
                  w_state_nxt  = ST_DONE;
               end
            end
         end
         ST_EXEC: begin
            w_rem_nxt = r_rem - WIDTH'(1);
            if (r_rem == WIDTH'(1)) begin
               // The bank takes its final step on this same edge, so capture
               // the value q is about to become rather than the stale one.
               w_result_nxt = jk_next(q, w_j, w_k);
               w_state_nxt  = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= '0;
         r_data   <= '0;
         r_rem    <= '0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_data   <= w_data_nxt;
         r_rem    <= w_rem_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign j         = w_j;
   assign k         = w_k;
   assign result    = r_result;

endmodule
